// File: rtl/sipo_ctrl_pkg.sv
// ============================================================================
// sipo_ctrl_pkg : shared types and helpers for the SIPO framing controller
// Rev 1.0
// ============================================================================
`default_nettype none

package sipo_ctrl_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    LOAD    = 1'b1
  } state_t;

  function automatic int IDX_W(input int width);
    return $clog2(width);
  endfunction

  // All-ones value of a w-bit counter, returned in a wide container.
  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter; a same-cycle inc and clr yields 1
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter
  import sipo_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      if (base != MAX) count <= base + W'(1);
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
// ============================================================================
// sipo_frame_ctrl : bit counting, word framing and holding-register handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OVF_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       ser_valid,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       clear_status,
  output logic                       sipo_shift_en,
  output logic                       word_load,
  output logic                       out_valid,
  output logic [IDX_W(WIDTH)-1:0]    bit_idx,
  output logic                       busy,
  output logic                       overflow,
  output logic                       frame_err,
  output logic [OVF_CNT_W-1:0]       ovf_count
);

  localparam int              IW   = IDX_W(WIDTH);
  localparam logic [IW-1:0]   LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0]   ONE  = IW'(1);

  state_t        state, state_n;
  logic [IW-1:0] idx_n;
  logic          accept;
  logic          ovf_evt;
  logic          ferr_evt;
  logic          valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      bit_idx   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= idx_n;
      out_valid <= valid_n;
      overflow  <= ovf_evt  ? 1'b1 : (clear_status ? 1'b0 : overflow);
      frame_err <= ferr_evt ? 1'b1 : (clear_status ? 1'b0 : frame_err);
    end
  end

  always_comb begin
    accept        = enable & ser_valid;
    sipo_shift_en = accept & ~rst;
    word_load     = (state == LOAD) & (~out_valid | out_ready) & ~rst;
    ovf_evt       = (state == LOAD) & out_valid & ~out_ready;
    ferr_evt      = (state == COLLECT) & accept & frame_start & (bit_idx != '0);
    busy          = (bit_idx != '0) | (state == LOAD);

    state_n = COLLECT;
    idx_n   = bit_idx;
    if (!enable) begin
      idx_n = '0;
    end else if (accept) begin
      // A bit arriving during LOAD is already bit 0 of the next word.
      if (state == LOAD || frame_start) begin
        idx_n = ONE;
      end else if (bit_idx == LAST) begin
        idx_n   = '0;
        state_n = LOAD;
      end else begin
        idx_n = bit_idx + ONE;
      end
    end

    if (word_load)                  valid_n = 1'b1;
    else if (out_valid & out_ready) valid_n = 1'b0;
    else                            valid_n = out_valid;
  end

  sat_counter #(
    .W (OVF_CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovf_evt),
    .clr   (clear_status),
    .count (ovf_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_ctrl.sv
// ============================================================================
// tb_sipo_frame_ctrl : directed scenarios plus random traffic vs a word model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sipo_frame_ctrl;

  localparam int WIDTH = 8;
  localparam int OW    = 8;
  localparam int CMAX  = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0, enable = 1'b0, ser_valid = 1'b0, frame_start = 1'b0;
  logic out_ready = 1'b0, clear_status = 1'b0;
  logic sipo_shift_en, word_load, out_valid, busy, overflow, frame_err;
  logic [$clog2(WIDTH)-1:0] bit_idx;
  logic [OW-1:0] ovf_count;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .OVF_CNT_W(OW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ser_valid(ser_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clear_status(clear_status),
    .sipo_shift_en(sipo_shift_en), .word_load(word_load), .out_valid(out_valid),
    .bit_idx(bit_idx), .busy(busy), .overflow(overflow), .frame_err(frame_err),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;
  logic last_load;

  // Reference model: bits gathered so far, whether a finished word awaits its
  // hand-off cycle, holding-register occupancy and the status counters.
  int m_bits = 0, m_full = 0, m_valid = 0, m_ovf = 0, m_ferr = 0, m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic s,
                     input logic f, input logic y, input logic c);
    int  n_bits, n_full, base;
    bit  acc, ld, drop, ferr_ev;
    rst = r; enable = e; ser_valid = s; frame_start = f; out_ready = y; clear_status = c;
    @(negedge clk);
    acc  = e && s;
    ld   = (m_full != 0) && (m_valid == 0 || y) && !r;
    drop = (m_full != 0) && (m_valid != 0) && !y;
    if (armed) begin
      chk("shift",     32'(sipo_shift_en), 32'(acc && !r));
      chk("load",      32'(word_load),     32'(ld));
      chk("busy",      32'(busy),          32'(m_bits != 0 || m_full != 0));
      chk("bit_idx",   32'(bit_idx),       32'(m_bits));
      chk("out_valid", 32'(out_valid),     32'(m_valid));
      chk("overflow",  32'(overflow),      32'(m_ovf));
      chk("frame_err", 32'(frame_err),     32'(m_ferr));
      chk("ovf_count", 32'(ovf_count),     32'(m_drops));
    end
    last_load = word_load;
    @(posedge clk);
    #1;
    if (r) begin
      m_bits = 0; m_full = 0; m_valid = 0; m_ovf = 0; m_ferr = 0; m_drops = 0;
      armed = 1'b1;
    end else begin
      ferr_ev = 1'b0;
      n_full  = 0;
      n_bits  = m_bits;
      if (!e) n_bits = 0;
      else if (acc) begin
        if (m_full != 0) n_bits = 1;
        else if (f) begin ferr_ev = (m_bits != 0); n_bits = 1; end
        else if (m_bits + 1 == WIDTH) begin n_bits = 0; n_full = 1; end
        else n_bits = m_bits + 1;
      end
      if (ld) m_valid = 1;
      else if (m_valid != 0 && y) m_valid = 0;
      base    = c ? 0 : m_drops;
      m_drops = drop ? ((base == CMAX) ? CMAX : base + 1) : base;
      m_ovf   = drop ? 1 : (c ? 0 : m_ovf);
      m_ferr  = ferr_ev ? 1 : (c ? 0 : m_ferr);
      m_bits  = n_bits;
      m_full  = n_full;
    end
  endtask

  task automatic send_word(input logic y, input logic c);
    for (int i = 0; i < WIDTH; i++) cyc(0, 1, 1, 0, y, 0);
    cyc(0, 1, 0, 0, y, c);
  endtask

  initial begin
    // Reset held while serial bits are offered.
    cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    chk("rst_idx", 32'(bit_idx), 0);
    chk("rst_valid", 32'(out_valid), 0);

    // Single word, then drain.
    for (int i = 0; i < WIDTH; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t2_load", 32'(last_load), 1);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t2_valid_off", 32'(out_valid), 0);

    // Back-to-back words.
    for (int i = 0; i < 2 * WIDTH; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_cnt", 32'(ovf_count), 0);

    // Backpressure: 24 bits with out_ready low.
    for (int i = 0; i < 3 * WIDTH; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t4_cnt", 32'(ovf_count), 2);
    chk("t4_valid", 32'(out_valid), 1);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t4_drain", 32'(out_valid), 0);

    // Resync mid-word, then clear the sticky error.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 1, 0);
    chk("t5_ferr", 32'(frame_err), 1);
    chk("t5_idx", 32'(bit_idx), 1);
    for (int i = 0; i < WIDTH - 1; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t5_load", 32'(last_load), 1);
    cyc(0, 1, 0, 0, 1, 1);
    chk("t5_clr", 32'(frame_err), 0);

    // Clear coinciding with an overflow event.
    cyc(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) send_word(0, 0);
    chk("t6_cnt5", 32'(ovf_count), 5);
    send_word(0, 1);
    chk("t6_cnt1", 32'(ovf_count), 1);
    chk("t6_ovf", 32'(overflow), 1);

    // Reset mid-word: no load may follow.
    cyc(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    chk("t6_rst_idx", 32'(bit_idx), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 0);

    // Saturation of the drop counter.
    for (int i = 0; i < 262 * WIDTH; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("sat_cnt", 32'(ovf_count), CMAX);

    // Random traffic.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 15) != 0),
          logic'($urandom_range(0, 3) != 0),   logic'($urandom_range(0, 19) == 0),
          logic'($urandom_range(0, 2) != 0),   logic'($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
